kbd_matrix: RTL
===============

KBD_MATRIX -- requirements
Module: kbd_matrix

Interface
REQ-001 SHALL have port clock, input, 1 bit: system clock; the only clock.
REQ-002 SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port strb, input, 1 bit: single-cycle pulse, a new scancode byte is on code.
REQ-004 SHALL have port code, input, 8 bits: raw PS/2 set-2 scancode byte, valid when strb=1.
REQ-005 SHALL have port row, input, 4 bits: Enterprise keyboard row select, 0-9 valid.
REQ-006 SHALL have port cols, output, 8 bits: column data for the selected row, active-low, 0 = key pressed.
REQ-007 SHALL have port kreset, output, 1 bit: high while F12 is held.

Function
REQ-008 SHALL hold an 80-bit key matrix, 10 rows x 8 bits, active-low, 1 = released.
REQ-009 SHALL decode bytes with a prefix FSM of states IDLE, EXT, BRK, EXTBRK and SKIP; every transition in REQ-010 to REQ-014 occurs only on strb=1.
REQ-010 IDLE handling:
- E0 -> EXT.
- F0 -> BRK.
- E1 -> SKIP with skip counter = 7.
- FA, AA, EE, FE -> ignored, state unchanged.
- 00, FF -> all matrix bits set to 1, state unchanged.
- Any other byte -> make event with ext=0, state stays IDLE.
REQ-011 EXT handling: F0 -> EXTBRK; E0 -> stay EXT; any other byte -> make event with ext=1, then IDLE.
REQ-012 BRK handling: any byte other than E0/F0 -> break event with ext=0, then IDLE; E0/F0 -> IDLE, no event.
REQ-013 EXTBRK handling: any byte other than E0/F0 -> break event with ext=1, then IDLE; E0/F0 -> IDLE, no event.
REQ-014 SKIP handling: each byte decrements the skip counter (3 bits) with no event; when the counter reaches 0 on a byte, go to IDLE (Pause sequence = E1 plus 7 bytes, all discarded).
REQ-015 Make/break events SHALL look up {ext, byte} in a combinational translation table giving valid, row (0-9) and col (0-7).
- Make clears the matrix bit.
- Break sets the matrix bit.
- valid=0 -> no matrix change.
REQ-016 The table SHALL contain at least these entries:
- 12 -> row0 col7.
- 59 -> row0 col7 (both shifts share a bit).
- 1C -> row2 col6.
- 5A -> row6 col6.
- 76 -> row3 col7.
- E0 75 -> row7 col1.
- E0 72 -> row7 col2.
- E0 6B -> row7 col3.
- E0 74 -> row7 col4.
- The remaining Enterprise keys follow the team keyboard map.
REQ-017 The matrix update SHALL take effect on the clock edge at which strb=1 (zero added latency).
REQ-018 cols SHALL be registered: cols at cycle n+1 = matrix[row sampled at n], with the update from cycle n already applied; row values 10-15 give cols=FF.
REQ-019 kreset SHALL be a registered level: set on a make of byte 07 with ext=0, cleared on a break of 07 or on a 00/FF flush.
REQ-020 Make of an already-pressed key and break of an already-released key SHALL be idempotent.
REQ-021 With strb=0, the FSM, matrix and kreset SHALL hold.
REQ-022 Row reads and scancode events SHALL be fully independent; an event and a read in the same cycle must both be honoured per REQ-018.

Reset
REQ-023 While reset=0, regardless of clock or mid-sequence state:
- matrix all 1.
- FSM in IDLE, skip counter 0.
- cols = FF.
- kreset = 0.
REQ-024 After reset release, the first byte SHALL be decoded from IDLE; a prefix received before reset has no effect.

Verification
REQ-025 Press/release: strb with 1C, then row=2 -> cols=BF next cycle; then F0, 1C -> cols=FF.
REQ-026 Extended key: E0, 75 -> row7 cols=FD; E0, F0, 75 -> row7 cols=FF; bare 75 (keypad 8) does not change row7.
REQ-027 Pause sequence: E1 14 77 E1 F0 14 F0 77 -> matrix unchanged, FSM in IDLE; a following 1C -> row2 cols=BF.
REQ-028 Flush and filter: press 12, 5A and 07, then send FF -> all rows FF and kreset=0; FA and AA from IDLE leave the state unchanged.
REQ-029 Reset mid-sequence: send E0, assert reset for 3 cycles, release, send 75 -> make of keypad 8, row7 unchanged, cols=FF during reset.
REQ-030 Shared bit and range: make 12 and 59, break 12 -> row0 cols=FF (last event wins); row=12 -> cols=FF.

Source files
------------

// File: rtl/kbd_matrix.sv
// kbd_matrix: PS/2 set-2 scancode decoder driving an Enterprise 10x8 active-low key matrix.
// Rows are read back through a registered column port; F12 drives a held-level reset request.
module kbd_matrix (
    input  logic       clock,
    input  logic       reset,
    input  logic       strb,
    input  logic [7:0] code,
    input  logic [3:0] row,
    output logic [7:0] cols,
    output logic       kreset
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_EXT    = 3'd1;
    localparam logic [2:0] S_BRK    = 3'd2;
    localparam logic [2:0] S_EXTBRK = 3'd3;
    localparam logic [2:0] S_SKIP   = 3'd4;

    logic [2:0]  r_state, w_state_nxt;
    logic [2:0]  r_skip, w_skip_nxt;
    logic [79:0] r_mat, w_mat;
    logic [7:0]  r_cols;
    logic        r_kreset, w_kreset_nxt;
    logic        w_make, w_brk, w_ext, w_flush, w_pfx, w_f12;
    logic [7:0]  w_ent;
    logic [6:0]  w_bit, w_sel;

    function automatic logic [7:0] ent(input logic [3:0] r, input logic [2:0] c);
        return {1'b1, r, c};
    endfunction

    assign w_pfx = (code == 8'hE0) || (code == 8'hF0);

    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip;
        w_make      = 1'b0;
        w_brk       = 1'b0;
        w_ext       = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (code == 8'hE0) w_state_nxt = S_EXT;
                else if (code == 8'hF0) w_state_nxt = S_BRK;
                else if (code == 8'hE1) begin
                    w_state_nxt = S_SKIP;
                    w_skip_nxt  = 3'd7;
                end
                else if (code == 8'h00 || code == 8'hFF) w_flush = 1'b1;
                else if (!(code inside {8'hFA, 8'hAA, 8'hEE, 8'hFE})) w_make = 1'b1;
            end
            S_EXT: begin
                w_ext = 1'b1;
                if (code == 8'hF0) w_state_nxt = S_EXTBRK;
                else if (code != 8'hE0) begin
                    w_make      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_BRK, S_EXTBRK: begin
                w_ext       = (r_state == S_EXTBRK);
                w_brk       = !w_pfx;
                w_state_nxt = S_IDLE;
            end
            S_SKIP: begin
                w_skip_nxt  = r_skip - 3'd1;
                w_state_nxt = (r_skip <= 3'd1) ? S_IDLE : S_SKIP;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Translation table: {ext, byte} -> {valid, row, col}
    always_comb begin
        w_ent = 8'h00;
        case ({w_ext, code})
            9'h031: w_ent = ent(4'd0, 3'd0);
            9'h05D: w_ent = ent(4'd0, 3'd1);
            9'h032: w_ent = ent(4'd0, 3'd2);
            9'h021: w_ent = ent(4'd0, 3'd3);
            9'h02A: w_ent = ent(4'd0, 3'd4);
            9'h022: w_ent = ent(4'd0, 3'd5);
            9'h01A: w_ent = ent(4'd0, 3'd6);
            9'h012, 9'h059: w_ent = ent(4'd0, 3'd7);
            9'h033: w_ent = ent(4'd1, 3'd0);
            9'h058: w_ent = ent(4'd1, 3'd1);
            9'h034: w_ent = ent(4'd1, 3'd2);
            9'h023: w_ent = ent(4'd1, 3'd3);
            9'h02B: w_ent = ent(4'd1, 3'd4);
            9'h01B: w_ent = ent(4'd1, 3'd5);
            9'h00E: w_ent = ent(4'd1, 3'd6);
            9'h014: w_ent = ent(4'd1, 3'd7);
            9'h03C: w_ent = ent(4'd2, 3'd0);
            9'h015: w_ent = ent(4'd2, 3'd1);
            9'h035: w_ent = ent(4'd2, 3'd2);
            9'h02D: w_ent = ent(4'd2, 3'd3);
            9'h02C: w_ent = ent(4'd2, 3'd4);
            9'h024: w_ent = ent(4'd2, 3'd5);
            9'h01C: w_ent = ent(4'd2, 3'd6);
            9'h00D: w_ent = ent(4'd2, 3'd7);
            9'h016: w_ent = ent(4'd3, 3'd0);
            9'h01E: w_ent = ent(4'd3, 3'd1);
            9'h026: w_ent = ent(4'd3, 3'd2);
            9'h025: w_ent = ent(4'd3, 3'd3);
            9'h02E: w_ent = ent(4'd3, 3'd4);
            9'h036: w_ent = ent(4'd3, 3'd5);
            9'h03D: w_ent = ent(4'd3, 3'd6);
            9'h076: w_ent = ent(4'd3, 3'd7);
            9'h005: w_ent = ent(4'd4, 3'd0);
            9'h006: w_ent = ent(4'd4, 3'd1);
            9'h004: w_ent = ent(4'd4, 3'd2);
            9'h00C: w_ent = ent(4'd4, 3'd3);
            9'h003: w_ent = ent(4'd4, 3'd4);
            9'h00B: w_ent = ent(4'd4, 3'd5);
            9'h083: w_ent = ent(4'd4, 3'd6);
            9'h00A: w_ent = ent(4'd4, 3'd7);
            9'h029: w_ent = ent(4'd5, 3'd0);
            9'h066: w_ent = ent(4'd5, 3'd1);
            9'h04E: w_ent = ent(4'd5, 3'd2);
            9'h055: w_ent = ent(4'd5, 3'd3);
            9'h046: w_ent = ent(4'd5, 3'd4);
            9'h045: w_ent = ent(4'd5, 3'd5);
            9'h03E: w_ent = ent(4'd5, 3'd6);
            9'h054: w_ent = ent(4'd5, 3'd7);
            9'h03B: w_ent = ent(4'd6, 3'd0);
            9'h042: w_ent = ent(4'd6, 3'd1);
            9'h04B: w_ent = ent(4'd6, 3'd2);
            9'h04C: w_ent = ent(4'd6, 3'd3);
            9'h052: w_ent = ent(4'd6, 3'd4);
            9'h05B: w_ent = ent(4'd6, 3'd5);
            9'h05A: w_ent = ent(4'd6, 3'd6);
            9'h061: w_ent = ent(4'd6, 3'd7);
            9'h043: w_ent = ent(4'd7, 3'd0);
            9'h175: w_ent = ent(4'd7, 3'd1);
            9'h172: w_ent = ent(4'd7, 3'd2);
            9'h16B: w_ent = ent(4'd7, 3'd3);
            9'h174: w_ent = ent(4'd7, 3'd4);
            9'h171: w_ent = ent(4'd7, 3'd5);
            9'h170: w_ent = ent(4'd7, 3'd6);
            9'h01D: w_ent = ent(4'd7, 3'd7);
            9'h03A: w_ent = ent(4'd8, 3'd0);
            9'h041: w_ent = ent(4'd8, 3'd1);
            9'h049: w_ent = ent(4'd8, 3'd2);
            9'h04A: w_ent = ent(4'd8, 3'd3);
            9'h011: w_ent = ent(4'd8, 3'd4);
            9'h044: w_ent = ent(4'd8, 3'd5);
            9'h04D: w_ent = ent(4'd8, 3'd6);
            9'h111: w_ent = ent(4'd8, 3'd7);
            9'h114: w_ent = ent(4'd9, 3'd0);
            9'h001: w_ent = ent(4'd9, 3'd1);
            9'h009: w_ent = ent(4'd9, 3'd2);
            9'h078: w_ent = ent(4'd9, 3'd3);
            9'h16C: w_ent = ent(4'd9, 3'd4);
            9'h169: w_ent = ent(4'd9, 3'd5);
            9'h17D: w_ent = ent(4'd9, 3'd6);
            9'h17A: w_ent = ent(4'd9, 3'd7);
            default: w_ent = 8'h00;
        endcase
    end

    assign w_bit = w_ent[6:0];
    assign w_sel = {row, 3'b000};
    assign w_f12 = !w_ext && (code == 8'h07);

    // Same-cycle update is visible to the row read registered on this edge
    always_comb begin
        w_mat = r_mat;
        if (strb && w_flush) w_mat = '1;
        else if (strb && w_ent[7] && (w_make || w_brk)) w_mat[w_bit] = w_brk;
    end

    assign w_kreset_nxt = w_flush ? 1'b0 : (w_f12 && w_make) ? 1'b1 : (w_f12 && w_brk) ? 1'b0 : r_kreset;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_skip   <= 3'd0;
            r_mat    <= '1;
            r_cols   <= 8'hFF;
            r_kreset <= 1'b0;
        end else begin
            r_mat  <= w_mat;
            r_cols <= (row <= 4'd9) ? w_mat[w_sel +: 8] : 8'hFF;
            if (strb) begin
                r_state  <= w_state_nxt;
                r_skip   <= w_skip_nxt;
                r_kreset <= w_kreset_nxt;
            end
        end
    end

    assign cols   = r_cols;
    assign kreset = r_kreset;
endmodule
